lsu_byte_master: RTL and testbench
==================================

Name: lsu_byte_master

Overview:
- Load/store initiator between the CPU's MEM stage and a byte-wide memory responder.
- Takes one load/store request per transaction, keyed by RISC-V func3.
- Serialises it into 1, 2 or 4 little-endian byte transfers over a req/ack bus.
- For loads, assembles the result and applies sign or zero extension before returning it to the core.

Parameters:
- ACK_TIMEOUT, 255: max cycles to wait for mem_ack per byte; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_valid  in  1  request valid
- core_ready  out  1  block can accept a request
- core_we  in  1  1=store, 0=load
- core_func3  in  3  access type (RISC-V load/store func3)
- core_addr  in  32  byte address
- core_wdata  in  32  store data; low bytes used for SB/SH
- core_done  out  1  one-cycle pulse: transaction finished
- core_err  out  1  valid with core_done: illegal func3, timeout or misaligned access
- core_rdata  out  32  load result; valid from core_done until the next accept
- mem_req  out  1  byte transfer request
- mem_we  out  1  byte write enable
- mem_addr  out  32  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, sampled in the ack cycle
- mem_ack  in  1  responder completes the current byte

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; core_ready=1; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; core_done=0; core_err=0; core_rdata=0; byte counter=0; timeout counter=0.
- Reset mid-transaction aborts it with no done pulse and drops mem_req immediately.
- States:
  - IDLE: core_ready=1. core_valid&core_ready accepts the request and latches we, func3, addr and wdata.
    - Legal func3 -> XFER.
    - Illegal func3 -> DONE with err=1 and no bus activity.
    - Legal loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
    - Legal stores: SB=000, SH=001, SW=010.
  - XFER: mem_req=1; mem_addr=addr+k, k=byte index 0..N-1; N=1/2/4 for B/H/W.
    - Address arithmetic is 32-bit and wraps modulo 2^32.
    - Store: mem_we=1, mem_wdata=wdata[8k+7:8k]. Load: mem_we=0.
    - mem_req stays asserted, with addr/we/wdata stable, until mem_ack.
    - Ack cycle: load captures mem_rdata into byte k; k increments; timeout counter clears.
    - If k was N-1 -> DONE. Otherwise the next cycle presents byte k+1 with mem_req still high.
    - mem_ack while mem_req=0 is ignored.
  - DONE: exactly one cycle. core_done=1, mem_req=0, core_ready=0, then -> IDLE.
    - Earliest next accept is the cycle after DONE.
- Latency: with a zero-wait responder (ack in the first req cycle), a transaction takes N XFER cycles plus 1 DONE cycle after the accept edge.
- Load result formation:
  - LB: sign-extend byte0.
  - LBU: zero-extend byte0.
  - LH: sign-extend {byte1,byte0}.
  - LHU: zero-extend {byte1,byte0}.
  - LW: {byte3,byte2,byte1,byte0}.
  - core_rdata updates only in DONE for a successful load.
  - Stores and errors leave core_rdata=0.
- Timeout (ACK_TIMEOUT>0): the counter increments each XFER cycle without ack.
  - Reaching ACK_TIMEOUT drops mem_req and goes to DONE with err=1.
  - Bytes already written are not rolled back.
- core_valid while core_ready=0 is ignored; it is not queued.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: for a halfword with addr[0]!=0, or a word with addr[1:0]!=0, go IDLE->DONE with err=1 and no mem_req.
- Undefined: misaligned accesses proceed bytewise at addr..addr+N-1 with no error.

Test Plan:
- SW addr=0x10, wdata=0xA1B2C3D4, zero-wait ack -> bytes D4,C3,B2,A1 written to 0x10..0x13 on consecutive cycles; core_done 5 cycles after accept; err=0.
- LB addr=0x20, mem byte=0x80 -> core_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH addr=0x22, mem 0x22=0x34, 0x23=0x92, responder waits 3 cycles per byte -> mem_req held stable during waits; core_rdata=0xFFFF9234. LHU at the same address -> 0x00009234.
- Store func3=100 -> core_done with err=1 the cycle after accept; mem_req never asserted.
- ACK_TIMEOUT=4, responder never acks -> mem_req high for 4 cycles, then core_done with err=1.
- Assert rst_n low mid-SW after byte 1 -> mem_req=0 immediately; no core_done. With LSU_MISALIGN_TRAP_EN defined, LW addr=0x3 -> err=1 with no bus activity. Without the macro, the same LW reads 0x3..0x6 with err=0.

Source files
------------

// File: rtl/lsu_byte_master_if.sv
// lsu_byte_master_if: core request/response and byte-wide memory bus bundle for the LSU byte master
interface lsu_byte_master_if;
   logic        core_valid;
   logic        core_ready;
   logic        core_we;
   logic [2:0]  core_func3;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic        core_done;
   logic        core_err;
   logic [31:0] core_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   modport master (
      input  core_valid, core_we, core_func3, core_addr, core_wdata, mem_rdata, mem_ack,
      output core_ready, core_done, core_err, core_rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport slave (
      output core_valid, core_we, core_func3, core_addr, core_wdata, mem_rdata, mem_ack,
      input  core_ready, core_done, core_err, core_rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_byte_master.sv
// lsu_byte_master: serialises RISC-V loads/stores into little-endian byte transfers; LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses
module lsu_byte_master #(
   parameter int ACK_TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst_n,
   lsu_byte_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] to_q, to_d;
   logic [1:0]  k_q, k_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        req_q, req_d;
   logic        mwe_q, mwe_d;
   logic [31:0] maddr_q, maddr_d;
   logic [7:0]  mwdata_q, mwdata_d;
   logic        accept, legal, misalign, last, tmo;
   logic [1:0]  last_k, k_nx;
   logic [31:0] buf_n, ext;
   // decode of the incoming request and of the byte currently on the bus
   always_comb begin
      accept = (state_q == IDLE) && ready_q && bus.core_valid;
      legal  = bus.core_we ? (bus.core_func3 inside {3'b000, 3'b001, 3'b010})
                           : (bus.core_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = ((bus.core_func3[1:0] == 2'b01) && bus.core_addr[0]) ||
                 ((bus.core_func3[1:0] == 2'b10) && (bus.core_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      last_k = f3_q[1] ? 2'd3 : {1'b0, f3_q[0]};
      last   = (k_q == last_k);
      k_nx   = k_q + 2'd1;
      tmo    = (ACK_TIMEOUT != 0) && ((to_q + 32'd1) >= 32'(ACK_TIMEOUT));
      buf_n  = buf_q;
      if (!we_q) buf_n[{k_q, 3'b000} +: 8] = bus.mem_rdata;
      ext = (f3_q == 3'b000) ? {{24{buf_n[7]}}, buf_n[7:0]} :
            (f3_q == 3'b100) ? {24'h0, buf_n[7:0]} :
            (f3_q == 3'b001) ? {{16{buf_n[15]}}, buf_n[15:0]} :
            (f3_q == 3'b101) ? {16'h0, buf_n[15:0]} : buf_n;
   end
   // next-state and next-output computation for the IDLE/XFER/DONE sequencer
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      f3_d     = f3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      buf_d    = buf_q;
      rdata_d  = rdata_q;
      to_d     = to_q;
      k_d      = k_q;
      ready_d  = ready_q;
      done_d   = done_q;
      err_d    = err_q;
      req_d    = req_q;
      mwe_d    = mwe_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      if (state_q == IDLE) begin
         if (accept) begin
            we_d    = bus.core_we;
            f3_d    = bus.core_func3;
            addr_d  = bus.core_addr;
            wdata_d = bus.core_wdata;
            k_d     = 2'd0;
            to_d    = 32'd0;
            buf_d   = 32'd0;
            ready_d = 1'b0;
            if (!legal || misalign) begin
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else begin
               state_d  = XFER;
               req_d    = 1'b1;
               mwe_d    = bus.core_we;
               maddr_d  = bus.core_addr;
               mwdata_d = bus.core_wdata[7:0];
            end
         end
      end else if (state_q == XFER) begin
         if (bus.mem_ack) begin
            buf_d = buf_n;
            to_d  = 32'd0;
            k_d   = k_nx;
            if (last) begin
               state_d = DONE;
               req_d   = 1'b0;
               mwe_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b0;
               rdata_d = we_q ? 32'd0 : ext;
            end else begin
               maddr_d  = addr_q + {30'd0, k_nx};
               mwdata_d = wdata_q[{k_nx, 3'b000} +: 8];
            end
         end else begin
            to_d = to_q + 32'd1;
            if (tmo) begin
               state_d = DONE;
               req_d   = 1'b0;
               mwe_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end
         end
      end else begin
         state_d = IDLE;
         done_d  = 1'b0;
         err_d   = 1'b0;
         ready_d = 1'b1;
      end
   end
   // state and registered outputs; reset aborts any transaction immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         f3_q     <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         buf_q    <= 32'd0;
         rdata_q  <= 32'd0;
         to_q     <= 32'd0;
         k_q      <= 2'd0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         mwe_q    <= 1'b0;
         maddr_q  <= 32'd0;
         mwdata_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         f3_q     <= f3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         buf_q    <= buf_d;
         rdata_q  <= rdata_d;
         to_q     <= to_d;
         k_q      <= k_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         err_q    <= err_d;
         req_q    <= req_d;
         mwe_q    <= mwe_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end
   assign bus.core_ready = ready_q;
   assign bus.core_done  = done_q;
   assign bus.core_err   = err_q;
   assign bus.core_rdata = rdata_q;
   assign bus.mem_req    = req_q;
   assign bus.mem_we     = mwe_q;
   assign bus.mem_addr   = maddr_q;
   assign bus.mem_wdata  = mwdata_q;
endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: directed checks of lsu_byte_master against a byte-wide responder model
module tb_lsu_byte_master;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   lsu_byte_master_if ifc();
   lsu_byte_master #(.ACK_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int req_cycles = 0;
   int done_cnt = 0;
   int stab_bad = 0;
   int wait_n = 0;
   int wcnt = 0;
   bit no_ack = 1'b0;
   logic [7:0]  mem [256];
   logic [31:0] wr_addr [$];
   logic [7:0]  wr_data [$];
   int          wr_cyc [$];
   logic [31:0] p_addr;
   logic        p_we;
   logic [7:0]  p_wd;
   int lat;
   logic err;
   logic [31:0] rd;
   int dc;
   // responder and bus monitor, decided on the falling edge for the next rising edge
   always @(negedge clk) begin
      cyc++;
      if (ifc.core_done === 1'b1) done_cnt++;
      if (ifc.mem_req === 1'b1) begin
         req_cycles++;
         if (wcnt > 0 && (ifc.mem_addr !== p_addr || ifc.mem_we !== p_we || ifc.mem_wdata !== p_wd)) stab_bad++;
         p_addr = ifc.mem_addr;
         p_we   = ifc.mem_we;
         p_wd   = ifc.mem_wdata;
      end
      if (ifc.mem_req === 1'b1 && !no_ack) begin
         if (wcnt == wait_n) begin
            ifc.mem_ack   = 1'b1;
            ifc.mem_rdata = mem[ifc.mem_addr[7:0]];
            if (ifc.mem_we) begin
               mem[ifc.mem_addr[7:0]] = ifc.mem_wdata;
               wr_addr.push_back(ifc.mem_addr);
               wr_data.push_back(ifc.mem_wdata);
               wr_cyc.push_back(cyc);
            end
            wcnt = 0;
         end else begin
            ifc.mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         ifc.mem_ack   = 1'b0;
         ifc.mem_rdata = 8'h00;
         wcnt          = 0;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output int l, output logic e, output logic [31:0] r);
      int n = 0;
      while (ifc.core_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      req_cycles     = 0;
      ifc.core_valid = 1'b1;
      ifc.core_we    = we;
      ifc.core_func3 = f3;
      ifc.core_addr  = a;
      ifc.core_wdata = wd;
      @(posedge clk);
      #1 ifc.core_valid = 1'b0;
      l = 0;
      e = 1'bx;
      r = 32'hxxxxxxxx;
      while (l < 100) begin
         @(negedge clk);
         l++;
         if (ifc.core_done === 1'b1) break;
      end
      e = ifc.core_err;
      r = ifc.core_rdata;
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      ifc.core_valid = 1'b0;
      ifc.core_we    = 1'b0;
      ifc.core_func3 = 3'd0;
      ifc.core_addr  = 32'd0;
      ifc.core_wdata = 32'd0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ifc.core_ready), 32'd1);
      chk("rst_req", 32'(ifc.mem_req), 32'd0);
      chk("rst_we", 32'(ifc.mem_we), 32'd0);
      chk("rst_addr", ifc.mem_addr, 32'd0);
      chk("rst_wdata", 32'(ifc.mem_wdata), 32'd0);
      chk("rst_done", 32'(ifc.core_done), 32'd0);
      chk("rst_err", 32'(ifc.core_err), 32'd0);
      chk("rst_rdata", ifc.core_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      wait_n = 0;
      run(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, lat, err, rd);
      chk("sw_lat", 32'(lat), 32'd5);
      chk("sw_err", 32'(err), 32'd0);
      chk("sw_rdata", rd, 32'd0);
      chk("sw_reqcyc", 32'(req_cycles), 32'd4);
      chk("sw_nwr", 32'(wr_addr.size()), 32'd4);
      if (wr_addr.size() == 4) begin
         chk("sw_a0", wr_addr[0], 32'h10);
         chk("sw_a3", wr_addr[3], 32'h13);
         chk("sw_d0", 32'(wr_data[0]), 32'hD4);
         chk("sw_d1", 32'(wr_data[1]), 32'hC3);
         chk("sw_d2", 32'(wr_data[2]), 32'hB2);
         chk("sw_d3", 32'(wr_data[3]), 32'hA1);
         chk("sw_consec", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
      end
      @(negedge clk);
      chk("done_pulse", 32'(ifc.core_done), 32'd0);
      chk("ready_back", 32'(ifc.core_ready), 32'd1);
      mem[8'h20] = 8'h80;
      run(1'b0, 3'b000, 32'h20, 32'd0, lat, err, rd);
      chk("lb_lat", 32'(lat), 32'd2);
      chk("lb_err", 32'(err), 32'd0);
      chk("lb_rdata", rd, 32'hFFFFFF80);
      repeat (2) @(negedge clk);
      chk("lb_hold", ifc.core_rdata, 32'hFFFFFF80);
      run(1'b0, 3'b100, 32'h20, 32'd0, lat, err, rd);
      chk("lbu_rdata", rd, 32'h00000080);
      mem[8'h22] = 8'h34;
      mem[8'h23] = 8'h92;
      wait_n = 3;
      stab_bad = 0;
      run(1'b0, 3'b001, 32'h22, 32'd0, lat, err, rd);
      chk("lh_lat", 32'(lat), 32'd9);
      chk("lh_rdata", rd, 32'hFFFF9234);
      chk("lh_reqcyc", 32'(req_cycles), 32'd8);
      chk("lh_stable", 32'(stab_bad), 32'd0);
      run(1'b0, 3'b101, 32'h22, 32'd0, lat, err, rd);
      chk("lhu_rdata", rd, 32'h00009234);
      chk("lhu_stable", 32'(stab_bad), 32'd0);
      wait_n = 0;
      run(1'b1, 3'b001, 32'h30, 32'hDEADBEEF, lat, err, rd);
      chk("sh_lat", 32'(lat), 32'd3);
      chk("sh_m30", 32'(mem[8'h30]), 32'hEF);
      chk("sh_m31", 32'(mem[8'h31]), 32'hBE);
      chk("sh_m32", 32'(mem[8'h32]), 32'h32);
      run(1'b1, 3'b100, 32'h40, 32'h12345678, lat, err, rd);
      chk("ill_st_lat", 32'(lat), 32'd1);
      chk("ill_st_err", 32'(err), 32'd1);
      chk("ill_st_req", 32'(req_cycles), 32'd0);
      run(1'b0, 3'b011, 32'h40, 32'd0, lat, err, rd);
      chk("ill_ld_err", 32'(err), 32'd1);
      chk("ill_ld_req", 32'(req_cycles), 32'd0);
      no_ack = 1'b1;
      run(1'b0, 3'b010, 32'h80, 32'd0, lat, err, rd);
      chk("to_lat", 32'(lat), 32'd5);
      chk("to_err", 32'(err), 32'd1);
      chk("to_reqcyc", 32'(req_cycles), 32'd4);
      chk("to_rdata", rd, 32'd0);
      no_ack = 1'b0;
      mem[3] = 8'h11;
      mem[4] = 8'h22;
      mem[5] = 8'h33;
      mem[6] = 8'h44;
      run(1'b0, 3'b010, 32'h3, 32'd0, lat, err, rd);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_lat", 32'(lat), 32'd1);
      chk("mis_err", 32'(err), 32'd1);
      chk("mis_req", 32'(req_cycles), 32'd0);
      chk("mis_rdata", rd, 32'd0);
`else
      chk("mis_lat", 32'(lat), 32'd5);
      chk("mis_err", 32'(err), 32'd0);
      chk("mis_req", 32'(req_cycles), 32'd4);
      chk("mis_rdata", rd, 32'h44332211);
`endif
      @(negedge clk);
      ifc.core_valid = 1'b1;
      ifc.core_we    = 1'b1;
      ifc.core_func3 = 3'b010;
      ifc.core_addr  = 32'h40;
      ifc.core_wdata = 32'h11223344;
      @(posedge clk);
      #1 ifc.core_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_addr", ifc.mem_addr, 32'h41);
      chk("mid_req", 32'(ifc.mem_req), 32'd1);
      dc = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort_req", 32'(ifc.mem_req), 32'd0);
      chk("abort_ready", 32'(ifc.core_ready), 32'd1);
      chk("abort_done", 32'(ifc.core_done), 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_nodone", 32'(done_cnt - dc), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run(1'b0, 3'b100, 32'h20, 32'd0, lat, err, rd);
      chk("post_rst_lbu", rd, 32'h00000080);
      chk("post_rst_err", 32'(err), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
